// File: rtl/me_pkg.sv
// Shared motion-estimation types and constants: pixel type, coordinate
// clamping helper and the default frame geometry used by the fetcher and
// the SAD array.
package me_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_FRAME_W = 1920;
    localparam int DEF_FRAME_H = 1080;
    localparam int DEF_PIX_W   = 8;

    typedef logic [DEF_PIX_W-1:0] pix_t;

    typedef enum logic {
        FS_IDLE,
        FS_ISSUE
    } fetch_state_t;

    // Clamp a signed coordinate into 0..hi.
    function automatic int clamp_coord(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/ref_bank.sv
// One column bank of the reference frame: simple dual-port RAM with a
// single write port and a registered read port. A read and a write to the
// same address in one cycle return the old pixel.
module ref_bank
    import me_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int PIX_W = DEF_PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    // NOTE: the array has no reset; clearing it would prevent block-RAM mapping.
    logic [PIX_W-1:0] mem [DEPTH];

    // Write port and registered read port.
    // NOTE: non-blocking assignments here give the read-old-data behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ref_block_fetch.sv
// Reference-frame store and N x N block fetcher. Serves one block row per
// cycle, two cycles after issue, with out-of-frame coordinates clamped to
// the frame edge.
module ref_block_fetch
    import me_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int XW      = $clog2(FRAME_W) + 1,
    parameter int YW      = $clog2(FRAME_H) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [XW-2:0]           wr_x,
    input  logic [YW-2:0]           wr_y,
    input  logic [PIX_W-1:0]        wr_data,
    input  logic                    req,
    input  logic signed [XW-1:0]    req_x,
    input  logic signed [YW-1:0]    req_y,
    output logic                    req_ready,
    output logic                    out_valid,
    output logic [$clog2(N)-1:0]    out_row,
    output logic                    out_last,
    output logic [N*PIX_W-1:0]      out_pix
);

    localparam int LOG_N = $clog2(N);
    localparam int WB    = FRAME_W / N;       // words per frame row in one bank
    localparam int DEPTH = WB * FRAME_H;
    localparam int AW    = $clog2(DEPTH);

    fetch_state_t state, state_n;
    logic                     issue;
    logic [LOG_N-1:0]         row_cnt;
    logic signed [XW-1:0]     x0;
    logic signed [YW-1:0]     y0;

    logic [AW-1:0]            wr_addr;
    logic [N-1:0][AW-1:0]     rd_addr;
    logic [N-1:0][PIX_W-1:0]  bank_q;
    logic [N-1:0][LOG_N-1:0]  sel;

    logic                     s1_valid;
    logic                     s1_last;
    logic [LOG_N-1:0]         s1_row;
    logic [N-1:0][LOG_N-1:0]  s1_sel;
    logic [N*PIX_W-1:0]       xbar;

    assign wr_addr = AW'(int'(wr_y) * WB + int'(wr_x >> LOG_N));

    for (genvar b = 0; b < N; b++) begin : g_bank
        ref_bank #(
            .DEPTH (DEPTH),
            .PIX_W (PIX_W),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_en && (wr_x[LOG_N-1:0] == LOG_N'(b))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_addr (rd_addr[b]),
            .rd_data (bank_q[b])
        );
    end

    // Next-state logic and handshake outputs.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            FS_IDLE: begin
                req_ready = 1'b1;
                if (req) begin
                    state_n = FS_ISSUE;
                end
            end
            FS_ISSUE: begin
                issue = 1'b1;
                if (row_cnt == LOG_N'(N - 1)) begin
                    state_n = FS_IDLE;
                end
            end
            default: state_n = FS_IDLE;
        endcase
    end

    // State register, row counter and latched block origin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FS_IDLE;
            row_cnt <= '0;
        end else begin
            state <= state_n;
            if (req && req_ready) begin
                x0      <= req_x;
                y0      <= req_y;
                row_cnt <= '0;
            end else if (issue) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // Per-bank read address and per-lane bank select for the issued row.
    // Bank bk serves the window column congruent to bk; clamping that column
    // gives the right address for clamped lanes too, since they fall on bank 0
    // or bank N-1 at the frame edge.
    always_comb begin
        int yr;
        int xb;
        yr      = clamp_coord(int'(y0) + int'(row_cnt), FRAME_H - 1);
        xb      = 0;
        rd_addr = '0;
        sel     = '0;
        for (int bk = 0; bk < N; bk++) begin
            xb          = int'(x0) + ((bk - int'(x0)) & (N - 1));
            rd_addr[bk] = AW'(yr * WB + clamp_coord(xb, FRAME_W - 1) / N);
        end
        for (int i = 0; i < N; i++) begin
            sel[i] = LOG_N'(clamp_coord(int'(x0) + i, FRAME_W - 1) % N);
        end
    end

    // Lane crossbar: rotation and edge replication in one select per lane.
    always_comb begin
        xbar = '0;
        for (int i = 0; i < N; i++) begin
            xbar[i*PIX_W +: PIX_W] = bank_q[s1_sel[i]];
        end
    end

    // Stage 1: tags travelling alongside the bank read register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_last  <= issue && (row_cnt == LOG_N'(N - 1));
        end
        s1_row <= row_cnt;
        s1_sel <= sel;
    end

    // Stage 2: crossbar output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_pix   <= '0;
        end else begin
            out_valid <= s1_valid;
            out_last  <= s1_last;
            out_row   <= s1_row;
            out_pix   <= xbar;
        end
    end

endmodule

// File: doc/ref_block_fetch.md
# ref_block_fetch

Parametrised reference-frame store and N×N block fetcher for the motion-estimation datapath. It holds one luma reference frame, accepts single-pixel writes from the frame loader, and serves N×N candidate blocks to the SAD array one row per cycle. Out-of-frame block coordinates are clamped to the frame edge, so search windows can overhang picture boundaries. Earlier designs had a fixed 4×4 combinational read with no edge handling; this block adds a request/valid handshake, a pipelined banked read, and clamping.

## Interface
- `N`, 4: block edge in pixels. Power of two, 2..16.
- `FRAME_W`, 1920: frame width in pixels. Must be a multiple of `N`.
- `FRAME_H`, 1080: frame height in pixels.
- `PIX_W`, 8: pixel width in bits.
- `XW` / `YW`, derived: `$clog2(FRAME_W)+1` / `$clog2(FRAME_H)+1`. Signed coordinate widths.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write one pixel this cycle.
- `wr_x` / `wr_y`  in  `XW-1` / `YW-1`  unsigned write coordinates, always in-frame.
- `wr_data`  in  `PIX_W`  write pixel.
- `req`  in  1  block fetch request.
- `req_x` / `req_y`  in  `XW` / `YW`  signed top-left coordinate of the block. May be negative or past the frame edge.
- `req_ready`  out  1  fetcher idle; a request is accepted when `req && req_ready`.
- `out_valid`  out  1  `out_pix` holds one block row.
- `out_row`  out  `$clog2(N)`  row index within the block.
- `out_last`  out  1  final row of the block.
- `out_pix`  out  `N*PIX_W`  pixels of the row; lane 0 (leftmost column) at the LSBs.

## Operation
- Storage is N column banks. Pixel (x,y) is stored in bank `x mod N` at address `y*(FRAME_W/N) + x/N`. Each bank has one write port and one registered read port.
- Clamping per lane i and row r:
  - `xi = clamp(req_x+i, 0, FRAME_W-1)`
  - `yr = clamp(req_y+r, 0, FRAME_H-1)`
- Lane i reads bank `xi mod N`. Clamped lanes request the same address as their edge neighbour, so bank conflicts cannot occur.
- A lane crossbar (rotate by `x0 mod N`, then replicate for clamped lanes) places bank data into output lanes.
- FSM:
  - IDLE: `req_ready`=1. On accept, latch `req_x`/`req_y`, set row counter to 0, go to ISSUE.
  - ISSUE: issue row r each cycle, r = 0..N-1. After issuing row N-1, go to IDLE.
- Pipeline: bank read register, then crossbar output register. Row r appears 2 cycles after it is issued.
- Writes are accepted in any state, including during ISSUE. Read-during-write to the same address returns the old pixel.
- Reset values: `req_ready`=1 (after reset released), `out_valid`=0, `out_last`=0, `out_row`=0, `out_pix`=0.
  - Reset mid-fetch aborts the block and flushes the pipeline valids.
  - Memory contents are not cleared by reset.

## Timing
- Request accepted at cycle T. Rows are issued at T+1..T+N. `req_ready`=0 during T+1..T+N and is 1 again at T+N+1.
- `out_valid`=1 for cycles T+3..T+N+2, with `out_row` = 0..N-1. `out_last`=1 at T+N+2.
- Back-to-back requests:
  - Minimum accept spacing is N+1 cycles.
  - The output stream has a 1-cycle bubble between blocks.
- No output backpressure. The consumer must accept every valid row.
- A write at cycle t is visible to any row issued at t+1 or later.

## Structure
- Package `me_pkg`:
  - `pix_t`
  - `clamp_coord` function
  - default `N`/`FRAME_W`/`FRAME_H`/`PIX_W` constants, shared with the SAD array
- Sub-module `ref_bank`: simple dual-port RAM, one write port and one registered read port. Instantiated N times via generate.
- FSM, clamping, address generation and the crossbar live in the top module.

## Test plan
- Fill the frame with `pix = (x+3y) mod 256`. Request (8,4) with N=4 → rows 0..3 with lane i = `(8+i+3(4+r)) mod 256`; `out_valid` at T+3..T+6; `out_last` only at T+6.
- Unaligned request (5,0) → lanes = pix(5..8,0). Checks the bank rotation across a bank boundary.
- Corner request (-2,-3) → every lane with x<0 equals the x=0 pixel; rows 0..3 equal frame rows 0,0,0,0.
- Request at (1918,1078) → lanes 2,3 replicate x=1919; rows 2,3 replicate y=1079.
- Write (1,1)=0xAA at T+1 during a fetch at (0,0) issued T → row 1 (issued T+2) shows 0xAA. Same write at T+2 → row 1 shows the old value.
- Deassert `rst_n` at T+2 of a fetch → `out_valid`=0 next cycle, `req_ready`=1 after release, no stray rows; a following fetch returns the pre-reset memory data.
